// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: pre-decodes JAL/JALR/B-type, predicts direction from a
// 2-bit counter table trained by execute, and predicts returns from a return-address stack.
module branch_predict_unit #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        pred_cf,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        ras_empty
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);
    localparam int unsigned PW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(RAS_DEPTH + 1);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic [1:0]     r_bht [BHT_ENTRIES];
    logic [31:0]    r_ras [RAS_DEPTH];
    logic [PW-1:0]  r_top;
    logic [CW-1:0]  r_count;

    logic [6:0]     w_opcode;
    logic [4:0]     w_rd;
    logic [4:0]     w_rs1;
    logic [31:0]    w_imm_j;
    logic [31:0]    w_imm_b;
    logic           w_is_jal;
    logic           w_is_jalr;
    logic           w_is_br;
    logic           w_link_rd;
    logic           w_link_rs1;
    logic [IDX-1:0] w_bht_idx;
    logic [IDX-1:0] w_upd_idx;
    logic           w_nonempty;
    logic [31:0]    w_top_val;
    logic [31:0]    w_link_addr;
    logic [PW-1:0]  w_top_inc;
    logic [PW-1:0]  w_top_dec;
    logic [31:0]    w_target;
    logic           w_push;
    logic           w_pop;
    logic           w_unused_upd;

    // Pre-decode of the fetched word
    assign w_opcode   = fetch_instr[6:0];
    assign w_rd       = fetch_instr[11:7];
    assign w_rs1      = fetch_instr[19:15];
    assign w_imm_j    = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                         fetch_instr[20], fetch_instr[30:21], 1'b0};
    assign w_imm_b    = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                         fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    assign w_is_jal   = fetch_valid && (w_opcode == OP_JAL);
    assign w_is_jalr  = fetch_valid && (w_opcode == OP_JALR);
    assign w_is_br    = fetch_valid && (w_opcode == OP_BR);
    assign w_link_rd  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_link_rs1 = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);

    assign w_bht_idx    = fetch_pc[IDX+1:2];
    assign w_upd_idx    = upd_pc[IDX+1:2];
    assign w_unused_upd = ^{upd_pc[31:IDX+2], upd_pc[1:0]};

    assign w_nonempty  = (r_count != '0);
    assign w_top_val   = r_ras[r_top];
    assign w_link_addr = fetch_pc + 32'd4;
    assign w_top_inc   = (r_top == PW'(RAS_DEPTH - 1)) ? '0 : r_top + PW'(1);
    assign w_top_dec   = (r_top == '0) ? PW'(RAS_DEPTH - 1) : r_top - PW'(1);
    assign ras_empty   = !w_nonempty;

    // Prediction and RAS request generation
    always_comb begin
        pred_cf    = 1'b0;
        pred_taken = 1'b0;
        w_target   = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        if (w_is_jal) begin
            pred_cf    = 1'b1;
            pred_taken = 1'b1;
            w_target   = fetch_pc + w_imm_j;
            w_push     = w_link_rd;
        end else if (w_is_br) begin
            pred_cf    = 1'b1;
            pred_taken = r_bht[w_bht_idx][1];
            w_target   = fetch_pc + w_imm_b;
        end else if (w_is_jalr) begin
            pred_cf = 1'b1;
            if (!w_link_rd && w_link_rs1) begin
                w_pop      = 1'b1;
                pred_taken = w_nonempty;
                w_target   = w_top_val;
            end else if (w_link_rd && !w_link_rs1) begin
                w_push = 1'b1;
            end else if (w_link_rd && w_link_rs1) begin
                w_push = 1'b1;
                if (w_rd != w_rs1) begin
                    w_pop      = 1'b1;
                    pred_taken = w_nonempty;
                    w_target   = w_top_val;
                end
            end
        end
    end

    assign pred_target = pred_taken ? w_target : '0;

    // Return-address stack; flush wins over any same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else if (flush) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push && w_pop && w_nonempty) begin
            r_ras[r_top] <= w_link_addr;
        end else if (w_push) begin
            r_top          <= w_top_inc;
            r_ras[w_top_inc] <= w_link_addr;
            if (r_count != CW'(RAS_DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_pop && w_nonempty) begin
            r_top   <= w_top_dec;
            r_count <= r_count - CW'(1);
        end
    end

    // Direction counters trained by resolved branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && (r_bht[w_upd_idx] != 2'b11)) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
            end else if (!upd_taken && (r_bht[w_upd_idx] != 2'b00)) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: counter training/saturation, RAS hints,
// overflow, same-cycle read/update, flush and asynchronous reset.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        pred_cf;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ras_empty;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_unit #(.BHT_ENTRIES(64), .RAS_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .flush       (flush),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .pred_cf     (pred_cf),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .ras_empty   (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = instr;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        #1;
    endtask

    task automatic pred(input string tag, input logic cf, input logic tk, input logic [31:0] tgt);
        chk({tag, ".cf"}, 32'(pred_cf), 32'(cf));
        chk({tag, ".taken"}, 32'(pred_taken), 32'(tk));
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    // Advance one edge and return all inputs to idle
    task automatic tick;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_instr = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        flush       = 1'b0;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_instr = '0;
        flush       = 1'b0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("reset.ras_empty", 32'(ras_empty), 32'd1);
        pred("reset.idle", 1'b0, 1'b0, 32'h0);

        // JAL on the bus without fetch_valid: no prediction
        fetch_instr = enc_j(5'd1, 21'h800);
        fetch_pc    = 32'h200;
        #1;
        pred("novalid", 1'b0, 1'b0, 32'h0);
        tick();
        chk("novalid.no_push", 32'(ras_empty), 32'd1);

        // Counter training at index 0
        fetch(32'h100, enc_b(13'd16));
        pred("br.c01", 1'b1, 1'b0, 32'h0);
        tick();
        upd(32'h100, 1'b1); tick();
        fetch(32'h100, enc_b(13'd16));
        pred("br.c10", 1'b1, 1'b1, 32'h110);
        tick();
        upd(32'h100, 1'b1); tick();
        fetch(32'h100, enc_b(13'd16)); pred("br.c11", 1'b1, 1'b1, 32'h110); tick();
        upd(32'h100, 1'b1); tick();
        fetch(32'h100, enc_b(13'd16)); pred("br.c11sat", 1'b1, 1'b1, 32'h110); tick();
        upd(32'h100, 1'b0); tick();
        fetch(32'h100, enc_b(13'd16)); pred("br.nt1", 1'b1, 1'b1, 32'h110); tick();
        upd(32'h100, 1'b0); tick();
        fetch(32'h100, enc_b(13'd16)); pred("br.nt2", 1'b1, 1'b0, 32'h0); tick();
        upd(32'h100, 1'b0); tick();
        upd(32'h100, 1'b1); tick();
        fetch(32'h100, enc_b(13'd16)); pred("br.c00sat", 1'b1, 1'b0, 32'h0); tick();

        // Negative branch offset wraps through the adder
        upd(32'h100, 1'b1); tick();
        fetch(32'h100, enc_b(13'h1FF0)); pred("br.neg", 1'b1, 1'b1, 32'hF0); tick();

        // Call / return pair
        fetch(32'h200, enc_j(5'd1, 21'h800));
        pred("jal.call", 1'b1, 1'b1, 32'hA00);
        tick();
        chk("jal.pushed", 32'(ras_empty), 32'd0);
        fetch(32'hA10, enc_jalr(5'd0, 5'd1));
        pred("jalr.ret", 1'b1, 1'b1, 32'h204);
        tick();
        chk("jalr.popped", 32'(ras_empty), 32'd1);
        fetch(32'hA20, enc_jalr(5'd0, 5'd6));
        pred("jalr.nohint", 1'b1, 1'b0, 32'h0);
        tick();

        // Overflow: five pushes into a depth-4 stack
        for (int k = 1; k <= 5; k++) begin
            fetch(32'(k) << 12, enc_j(5'd5, 21'h10));
            tick();
        end
        fetch(32'h8000, enc_jalr(5'd0, 5'd5)); pred("ovf.pop1", 1'b1, 1'b1, 32'h5004); tick();
        fetch(32'h8000, enc_jalr(5'd0, 5'd1)); pred("ovf.pop2", 1'b1, 1'b1, 32'h4004); tick();
        fetch(32'h8000, enc_jalr(5'd0, 5'd1)); pred("ovf.pop3", 1'b1, 1'b1, 32'h3004); tick();
        fetch(32'h8000, enc_jalr(5'd0, 5'd1)); pred("ovf.pop4", 1'b1, 1'b1, 32'h2004); tick();
        fetch(32'h8000, enc_jalr(5'd0, 5'd1)); pred("ovf.pop5", 1'b1, 1'b0, 32'h0); tick();
        chk("ovf.empty", 32'(ras_empty), 32'd1);

        // Pop-then-push and push-only hints
        fetch(32'h2FC, enc_j(5'd1, 21'h10)); tick();
        fetch(32'h400, enc_jalr(5'd1, 5'd5)); pred("swap", 1'b1, 1'b1, 32'h300); tick();
        fetch(32'h500, enc_jalr(5'd1, 5'd1)); pred("pushonly", 1'b1, 1'b0, 32'h0); tick();
        fetch(32'h600, enc_jalr(5'd0, 5'd1)); pred("swap.pop1", 1'b1, 1'b1, 32'h504); tick();
        fetch(32'h600, enc_jalr(5'd0, 5'd1)); pred("swap.pop2", 1'b1, 1'b1, 32'h404); tick();
        chk("swap.count", 32'(ras_empty), 32'd1);
        fetch(32'h700, enc_jalr(5'd5, 5'd1)); pred("swap.empty", 1'b1, 1'b0, 32'h0); tick();
        chk("swap.empty_push", 32'(ras_empty), 32'd0);
        fetch(32'h710, enc_jalr(5'd0, 5'd5)); pred("swap.empty_pop", 1'b1, 1'b1, 32'h704); tick();
        chk("swap.empty_done", 32'(ras_empty), 32'd1);

        // Same-cycle read and update at index 1
        fetch(32'h104, enc_b(13'd16));
        upd(32'h104, 1'b1);
        pred("bypass.old", 1'b1, 1'b0, 32'h0);
        tick();
        fetch(32'h104, enc_b(13'd16));
        pred("bypass.new", 1'b1, 1'b1, 32'h114);
        tick();

        // Flush beats a same-cycle push and clears a non-empty stack
        fetch(32'h900, enc_j(5'd1, 21'h10)); tick();
        chk("flush.pre", 32'(ras_empty), 32'd0);
        flush = 1'b1;
        fetch(32'h600, enc_j(5'd1, 21'h40));
        pred("flush.pred", 1'b1, 1'b1, 32'h640);
        tick();
        chk("flush.empty", 32'(ras_empty), 32'd1);
        fetch(32'h610, enc_jalr(5'd0, 5'd1)); pred("flush.pop", 1'b1, 1'b0, 32'h0); tick();

        // Asynchronous reset mid-sequence
        upd(32'h104, 1'b1); tick();
        fetch(32'h3000, enc_j(5'd1, 21'h10)); tick();
        chk("rst.pre", 32'(ras_empty), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_empty", 32'(ras_empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        fetch(32'h104, enc_b(13'd16)); pred("rst.c01", 1'b1, 1'b0, 32'h0); tick();
        upd(32'h104, 1'b1); tick();
        fetch(32'h104, enc_b(13'd16)); pred("rst.c10", 1'b1, 1'b1, 32'h114); tick();
        fetch(32'h100, enc_b(13'd16)); pred("rst.idx0", 1'b1, 1'b0, 32'h0); tick();
        fetch(32'h620, enc_jalr(5'd0, 5'd1)); pred("rst.ras", 1'b1, 1'b0, 32'h0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Fetch-stage branch predictor for the RISC-V pipeline: pre-decodes the fetched instruction, predicts direction and target for JAL, JALR and B-type instructions, and redirects fetch in the same cycle. Direction state is a parametrised table of 2-bit saturating counters trained by the execute stage. Return targets come from a parametrised return-address stack (RAS). Sits between the instruction memory read port and the PC-select mux; it replaces the purely combinational pre-decoder with a stateful one.

## Interface
- BHT_ENTRIES, 64, number of 2-bit counters; power of 2, ≥2; IDX = log2(BHT_ENTRIES)
- RAS_DEPTH, 4, return-address stack entries; ≥1
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_valid  input  1  fetch_pc/fetch_instr valid and accepted this cycle
- fetch_pc  input  32  PC of fetched instruction
- fetch_instr  input  32  fetched instruction word
- flush  input  1  pipeline redirect from execute; clears RAS
- upd_valid  input  1  B-type branch resolved in execute this cycle
- upd_pc  input  32  PC of resolved branch
- upd_taken  input  1  actual outcome of resolved branch
- pred_cf  output  1  fetched instr is JAL, JALR or B-type (and fetch_valid)
- pred_taken  output  1  redirect fetch to pred_target
- pred_target  output  32  predicted target; 0 when pred_taken=0
- ras_empty  output  1  RAS count == 0

## Operation
- Pre-decode: opcode=instr[6:0]; JAL 1101111, JALR 1100111, B-type 1100011; rd=[11:7], rs1=[19:15]. Immediates sign-extended: J={instr[31],[19:12],[20],[30:21],0}, B={instr[31],[7],[30:25],[11:8],0}. Targets add to fetch_pc modulo 2^32.
- link(r) = (r==x1 || r==x5).
- B-type: index = fetch_pc[IDX+1:2]; pred_taken = bht[index][1]; target = pc+B_imm.
- JAL: pred_taken=1, target=pc+J_imm; if link(rd) push pc+4.
- JALR, by rd/rs1 (RISC-V RAS hints):
  - !link(rd) && link(rs1): pop; taken=1, target=top if non-empty, else taken=0.
  - link(rd) && !link(rs1): push pc+4; taken=0.
  - link(rd) && link(rs1) && rd!=rs1: pop then push; target=old top (taken=0 if empty), new top=pc+4, count unchanged if non-empty else becomes 1.
  - link(rd) && link(rs1) && rd==rs1: push only; taken=0.
  - otherwise: taken=0, no RAS change.
- Non-control-flow or fetch_valid=0: pred_cf=0, pred_taken=0, pred_target=0, no state change.
- RAS: circular buffer, top pointer + count. Push when full overwrites oldest; count saturates at RAS_DEPTH. Pop when empty: no change.
- BHT update on upd_valid: counter at upd_pc[IDX+1:2] increments if upd_taken (saturate 11), else decrements (saturate 00).
- flush: RAS count→0, pointer→0 next edge; BHT untouched; flush has priority over any same-cycle fetch push/pop (suppressed). Predictions in a flush cycle are still driven but ignored by fetch.

## Timing
- Predictions combinational from fetch inputs and registered state: 0-cycle latency.
- All state updates on the rising clk edge after the qualifying cycle.
- Fetch read and update to the same BHT index in one cycle: prediction uses the pre-update value; update lands next edge.
- Update and fetch touch disjoint state (BHT vs RAS), so no further conflict.
- Reset (async, any time, including mid-operation): every BHT counter = 01 (weakly not-taken), RAS entries = 0, count = 0, pointer = 0. All outputs follow from that state: pred_cf/pred_taken/pred_target = 0 unless a valid control-flow instruction is presented; ras_empty = 1.
- Deassertion of rst_n is synchronised externally; the first edge after release is a normal cycle.

## Test plan
- Reset, B-type at pc 0x100 with imm +16 -> pred_cf=1, pred_taken=0 (counter 01); after 1 upd_taken=1 -> pred_taken=1, target 0x110; two more taken then three not-taken -> taken, taken, taken, not-taken (saturation at 11 verified).
- JAL x1,+0x800 at 0x200 -> taken, target 0xA00, push 0x204; then JALR x0,0(x1) at 0xA10 -> taken, target 0x204, ras_empty=1 after.
- RAS_DEPTH=4: push 5 returns (0x1004..0x5004) then 5 pops -> targets 0x5004, 0x4004, 0x3004, 0x2004, then taken=0 (oldest overwritten).
- JALR x1,0(x5) with RAS top 0x300 -> target 0x300, new top = pc+4, count unchanged; JALR x1,0(x1) -> push only, taken=0.
- Same-cycle upd_valid and fetch at same index, counter 01, upd_taken=1 -> this cycle taken=0, next cycle taken=1.
- flush with a JAL x1 fetch in the same cycle -> no push, ras_empty=1 next cycle; assert rst_n low mid-sequence -> all counters back to 01, RAS empty.
